// File: rtl/bram_sdp_ext_pkg.sv
// Shared definitions for the simple-dual-port block RAM family.
//   clogb2            : index of the most significant set bit, used to size address ports
//   Collision*        : accepted values of the collision_mode parameter
//   StInit / StRun    : encodings of the post-reset clear sequencer states
package bram_sdp_ext_pkg;

    localparam string CollisionWriteFirst = "WRITE_FIRST";
    localparam string CollisionReadFirst  = "READ_FIRST";

    localparam logic [0:0] StInit = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    // floor(log2(value)); clogb2(value)+1 is the bit count needed to hold value.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value;
        r = 0;
        while (v > 1) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_sdp_ext_init_seq.sv
// Post-reset clear sequencer for bram_sdp_ext.
// With init_en set it walks every address once, requesting a full-word write of init_value,
// then enters RUN and raises init_done one cycle later. Without init_en it starts in RUN.
//   clk, rst_n  : clock, asynchronous active-low reset
//   init_done   : memory usable (registered)
//   init_we     : clear write request, valid while in INIT
//   init_addr   : clear write address (the counter)
//   init_data   : clear pattern
module bram_sdp_ext_init_seq
    import bram_sdp_ext_pkg::*;
#(
    parameter int unsigned          mem_width  = 32,
    parameter int unsigned          mem_depth  = 4096,
    parameter int unsigned          addr_width = 12,
    parameter bit                   init_en    = 1'b1,
    parameter logic [mem_width-1:0] init_value = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    output logic                  init_we,
    output logic [addr_width-1:0] init_addr,
    output logic [mem_width-1:0]  init_data
);

    localparam logic [0:0]            StReset  = init_en ? StInit : StRun;
    localparam logic [addr_width-1:0] LastAddr = addr_width'(mem_depth - 1);

    logic [0:0]            state_q, state_d;
    logic [addr_width-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        case (state_q)
            StInit: begin
                // Counter parks on the last address so it never wraps.
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun:   done_d  = 1'b1;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StReset;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign init_done = done_q;
    assign init_we   = (state_q == StInit);
    assign init_addr = cnt_q;
    assign init_data = init_value;

endmodule

// File: rtl/bram_sdp_ext.sv
// Simple-dual-port block RAM: port A writes with byte-lane enables, port B reads with a
// configurable latency of 1..4 cycles and a one-cycle read-valid pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   init_done   : 1 = memory usable, 0 while the post-reset clear runs
//   wen_a       : per-lane write enables (mem_width/byte_width lanes)
//   addr_a      : write address
//   din_a       : write data
//   ren_b       : read request
//   addr_b      : read address
//   dout_b      : read data, updated only together with dout_vld_b, held otherwise
//   dout_vld_b  : one pulse per accepted read, read_latency cycles after acceptance
module bram_sdp_ext
    import bram_sdp_ext_pkg::*;
#(
    parameter int unsigned          mem_width      = 32,
    parameter int unsigned          mem_depth      = 4096,
    parameter int unsigned          byte_width     = 8,
    parameter int unsigned          read_latency   = 2,
    parameter string                collision_mode = "WRITE_FIRST",
    parameter string                init_on_reset  = "true",
    parameter logic [mem_width-1:0] init_value     = '0,
    localparam int unsigned         aw             = clogb2(mem_depth - 1) + 1,
    localparam int unsigned         nl             = mem_width / byte_width
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_done,
    input  logic [nl-1:0]        wen_a,
    input  logic [aw-1:0]        addr_a,
    input  logic [mem_width-1:0] din_a,
    input  logic                 ren_b,
    input  logic [aw-1:0]        addr_b,
    output logic [mem_width-1:0] dout_b,
    output logic                 dout_vld_b
);

    if (mem_width % byte_width != 0) begin : g_bad_width
        $error("bram_sdp_ext: mem_width must be a multiple of byte_width");
    end
    if (read_latency < 1 || read_latency > 4) begin : g_bad_latency
        $error("bram_sdp_ext: read_latency must be within 1..4");
    end
    if (mem_depth < 2) begin : g_bad_depth
        $error("bram_sdp_ext: mem_depth must be at least 2");
    end
    if (collision_mode != CollisionWriteFirst && collision_mode != CollisionReadFirst)
    begin : g_bad_collision
        $error("bram_sdp_ext: collision_mode must be WRITE_FIRST or READ_FIRST");
    end
    if (init_on_reset != "true" && init_on_reset != "false") begin : g_bad_init
        $error("bram_sdp_ext: init_on_reset must be true or false");
    end

    localparam bit          write_first = (collision_mode == CollisionWriteFirst);
    localparam bit          init_en     = (init_on_reset == "true");
    localparam logic [aw:0] depth_ext   = (aw + 1)'(mem_depth);

    (* ram_style = "block" *) logic [mem_width-1:0] mem [mem_depth];

    logic                 init_we;
    logic [aw-1:0]        init_addr;
    logic [mem_width-1:0] init_data;

    bram_sdp_ext_init_seq #(
        .mem_width  (mem_width),
        .mem_depth  (mem_depth),
        .addr_width (aw),
        .init_en    (init_en),
        .init_value (init_value)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // Addresses at or above mem_depth only exist for non-power-of-2 depths.
    logic a_in_range, b_in_range;
    assign a_in_range = ({1'b0, addr_a} < depth_ext);
    assign b_in_range = ({1'b0, addr_b} < depth_ext);

    // Write port: the clear sequencer owns the array while in INIT.
    logic [nl-1:0]        wr_lanes;
    logic [aw-1:0]        wr_addr;
    logic [mem_width-1:0] wr_data;

    always_comb begin
        wr_lanes = '0;
        wr_addr  = addr_a;
        wr_data  = din_a;
        if (init_we) begin
            wr_lanes = '1;
            wr_addr  = init_addr;
            wr_data  = init_data;
        end else if (init_done && a_in_range) begin
            wr_lanes = wen_a;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < nl; i++) begin
            if (wr_lanes[i]) begin
                mem[wr_addr][i*byte_width +: byte_width] <= wr_data[i*byte_width +: byte_width];
            end
        end
    end

    // Read side: sample the old word, then overlay same-edge written lanes for WRITE_FIRST.
    logic                 rd_accept;
    logic                 collision;
    logic [mem_width-1:0] rd_old;
    logic [mem_width-1:0] rd_merged;

    assign rd_accept = ren_b && init_done;
    assign collision = init_done && a_in_range && (|wen_a) && (addr_a == addr_b);

    always_comb begin
        rd_old    = b_in_range ? mem[addr_b] : '0;
        rd_merged = rd_old;
        if (write_first && collision) begin
            for (int unsigned i = 0; i < nl; i++) begin
                if (wen_a[i]) begin
                    rd_merged[i*byte_width +: byte_width] = din_a[i*byte_width +: byte_width];
                end
            end
        end
    end

    // Latency pipeline: a data stage only loads when its valid arrives, so the last stage
    // holds the most recent word between pulses.
    logic [read_latency-1:0] vld_pipe_q;
    logic [mem_width-1:0]    data_pipe_q [read_latency];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            for (int unsigned k = 0; k < read_latency; k++) begin
                data_pipe_q[k] <= '0;
            end
        end else begin
            vld_pipe_q[0] <= rd_accept;
            if (rd_accept) begin
                data_pipe_q[0] <= rd_merged;
            end
            for (int unsigned k = 1; k < read_latency; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                if (vld_pipe_q[k-1]) begin
                    data_pipe_q[k] <= data_pipe_q[k-1];
                end
            end
        end
    end

    assign dout_vld_b = vld_pipe_q[read_latency-1];
    assign dout_b     = data_pipe_q[read_latency-1];

endmodule

// File: tb/tb_bram_sdp_ext.sv
// Bench for bram_sdp_ext: four instances (read latency 1..4; latencies 1,2 WRITE_FIRST,
// 3,4 READ_FIRST) share one stimulus stream. Each issued read pushes its expected word and
// arrival cycle per instance; a negedge monitor pops on every dout_vld_b.
module tb_bram_sdp_ext;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  wen_a;
    logic [3:0]  addr_a;
    logic [31:0] din_a;
    logic        ren_b;
    logic [3:0]  addr_b;

    logic [31:0] dout [4];
    logic        vld  [4];
    logic        done [4];

    exp_t        exp_q [4][$];
    logic [31:0] last  [4];
    exp_t        mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        if (g < 2) begin : g_wf
            bram_sdp_ext #(
                .mem_width(32), .mem_depth(16), .byte_width(8), .read_latency(g + 1),
                .collision_mode("WRITE_FIRST"), .init_on_reset("true"),
                .init_value(32'hA5A5A5A5)
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .init_done(done[g]),
                .wen_a(wen_a), .addr_a(addr_a), .din_a(din_a),
                .ren_b(ren_b), .addr_b(addr_b), .dout_b(dout[g]), .dout_vld_b(vld[g])
            );
        end else begin : g_rf
            bram_sdp_ext #(
                .mem_width(32), .mem_depth(16), .byte_width(8), .read_latency(g + 1),
                .collision_mode("READ_FIRST"), .init_on_reset("true"),
                .init_value(32'hA5A5A5A5)
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .init_done(done[g]),
                .wen_a(wen_a), .addr_a(addr_a), .din_a(din_a),
                .ren_b(ren_b), .addr_b(addr_b), .dout_b(dout[g]), .dout_vld_b(vld[g])
            );
        end
    end

    task automatic check(input string name, input int g, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, g, got, want);
        end
    endtask

    // Monitor: reset values, in-order data with exact arrival cycle, hold between pulses.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (!rst_n) begin
                check("reset_vld", g, 32'(vld[g]), 32'd0);
                check("reset_dout", g, dout[g], 32'd0);
                last[g] = '0;
            end else if (vld[g]) begin
                if (exp_q[g].size() == 0) begin
                    check("unexpected_vld", g, 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[g].pop_front();
                    check("rd_data", g, dout[g], mon_e.data);
                    check("rd_cycle", g, 32'(cyc), 32'(mon_e.cyc));
                end
                last[g] = dout[g];
            end else begin
                check("dout_hold", g, dout[g], last[g]);
            end
        end
    end

    task automatic idle_inputs();
        wen_a  = '0;
        addr_a = '0;
        din_a  = '0;
        ren_b  = 1'b0;
        addr_b = '0;
    endtask

    // One clock of stimulus; ewf/erf are the expected read words for WRITE_FIRST/READ_FIRST.
    task automatic step(input logic [3:0] we, input logic [3:0] aa, input logic [31:0] d,
                        input logic re, input logic [3:0] ab,
                        input logic [31:0] ewf, input logic [31:0] erf);
        exp_t e;
        wen_a  = we;
        addr_a = aa;
        din_a  = d;
        ren_b  = re;
        addr_b = ab;
        if (re) begin
            for (int g = 0; g < 4; g++) begin
                e.data = (g < 2) ? ewf : erf;
                e.cyc  = cyc + g + 1;
                exp_q[g].push_back(e);
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Release reset and count edges until init_done; junk drives both ports during INIT.
    task automatic wait_init(input bit junk);
        int n;
        n = 0;
        if (junk) begin
            wen_a  = 4'hF;
            addr_a = 4'd0;
            din_a  = 32'hDEADBEEF;
            ren_b  = 1'b1;
            addr_b = 4'd0;
        end
        rst_n = 1'b1;
        while (!done[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle_inputs();
        check("init_cycles", 0, 32'(n), 32'd17);
        for (int g = 0; g < 4; g++) check("init_done_high", g, 32'(done[g]), 32'd1);
    endtask

    task automatic check_init_low();
        for (int g = 0; g < 4; g++) check("init_done_reset", g, 32'(done[g]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_init_low();
        wait_init(1'b1);

        // Whole array cleared; the write to address 0 during INIT must not land.
        for (int i = 0; i < 16; i++) begin
            step(4'h0, 4'd0, 32'd0, 1'b1, i[3:0], 32'hA5A5A5A5, 32'hA5A5A5A5);
        end

        // Single isolated read: arrival cycle per latency, then hold.
        step(4'hF, 4'd3, 32'h00001234, 1'b0, 4'd0, 32'd0, 32'd0);
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h00001234, 32'h00001234);
        repeat (6) step(4'h0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);

        // Byte lanes.
        step(4'hF, 4'd0, 32'h11223344, 1'b0, 4'd0, 32'd0, 32'd0);
        step(4'b0101, 4'd0, 32'hAABBCCDD, 1'b0, 4'd0, 32'd0, 32'd0);
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd0, 32'h11BB33DD, 32'h11BB33DD);

        // Same-edge collision, then a plain read of the written word.
        step(4'hF, 4'd5, 32'h00000000, 1'b0, 4'd0, 32'd0, 32'd0);
        step(4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 32'h0000FFFF, 32'h00000000);
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h0000FFFF, 32'h0000FFFF);

        // Streaming: eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            step(4'hF, i[3:0], 32'hC0DE0000 + i, 1'b0, 4'd0, 32'd0, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            step(4'h0, 4'd0, 32'd0, 1'b1, i[3:0], 32'hC0DE0000 + i, 32'hC0DE0000 + i);
        end
        repeat (5) step(4'h0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);

        // A write after the read edge must not alter the returned word.
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hC0DE0003, 32'hC0DE0003);
        step(4'hF, 4'd3, 32'h00005678, 1'b0, 4'd0, 32'd0, 32'd0);
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h00005678, 32'h00005678);
        repeat (5) step(4'h0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);

        // Reset with two reads in flight: pending pulses are discarded, clear reruns.
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h00005678, 32'h00005678);
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hC0DE0004, 32'hC0DE0004);
        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) exp_q[g].delete();
        repeat (2) @(posedge clk);
        #1;
        check_init_low();
        wait_init(1'b0);
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hA5A5A5A5, 32'hA5A5A5A5);
        step(4'h0, 4'd0, 32'd0, 1'b1, 4'd0, 32'hA5A5A5A5, 32'hA5A5A5A5);

        for (int n = 0; n < 10; n++) begin
            if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0)
                break;
            step(4'h0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        end
        for (int g = 0; g < 4; g++) check("queue_drained", g, 32'(exp_q[g].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
